// File: rtl/decode_stage_ctrl.sv
// decode_stage_ctrl: registered MIPS control decoder between the fetch latch
// and the execute stage, with valid/ready flow control.
//   clk, n_rst            : core clock; asynchronous reset, active high
//   instr_valid/instr_ready/instruction : fetch-side handshake and word
//   flush                 : synchronous kill of the output register and hazard state
//   dec_valid/dec_ready   : execute-side handshake
//   opcode..isjr          : registered control bundle
//   halt                  : sticky, set when a HALT is accepted, cleared by reset only
// Load-use stalls: after an LW, up to LU_BUBBLES advance cycles are spent
// refusing any instruction that reads the load destination.
module decode_stage_ctrl #(
    parameter int LU_BUBBLES    = 1,
    parameter int SHAMT_W       = 32,
    parameter bit ZERO_REG_SKIP = 1'b1
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               instr_valid,
    input  logic [31:0]        instruction,
    output logic               instr_ready,
    input  logic               flush,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [5:0]         opcode,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         wsel,
    output logic [SHAMT_W-1:0] shamt,
    output logic [15:0]        imm,
    output logic [3:0]         aluop,
    output logic [1:0]         alusrc,
    output logic               extop,
    output logic               regwr,
    output logic               memtoreg,
    output logic               dren,
    output logic               dwen,
    output logic               isjr,
    output logic               halt
);
    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04,
        OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
        OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI   = 6'h0D, OP_XORI = 6'h0E,
        OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW    = 6'h2B, OP_HALT = 6'h3F
    } opcode_t;

    typedef enum logic [5:0] {
        F_SLL = 6'h00, F_SRL  = 6'h02, F_JR  = 6'h08, F_ADD = 6'h20,
        F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24,
        F_OR  = 6'h25, F_XOR  = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A,
        F_SLTU = 6'h2B
    } funct_t;

    typedef enum logic [3:0] {
        ALU_SLL = 4'h0, ALU_SRL = 4'h1, ALU_ADD = 4'h2, ALU_SUB  = 4'h3,
        ALU_AND = 4'h4, ALU_OR  = 4'h5, ALU_XOR = 4'h6, ALU_NOR  = 4'h7,
        ALU_SLT = 4'hA, ALU_SLTU = 4'hB
    } aluop_t;

    typedef struct packed {
        opcode_t     op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wsel;
        logic [4:0]  sa;
        logic [15:0] imm;
        aluop_t      aluop;
        logic [1:0]  alusrc;
        logic        extop;
        logic        regwr;
        logic        memtoreg;
        logic        dren;
        logic        dwen;
        logic        isjr;
        logic        is_halt;
    } bundle_t;

    localparam int CNT_W = (LU_BUBBLES > 0) ? $clog2(LU_BUBBLES + 1) : 1;

    bundle_t    d, bnd_q;
    opcode_t    op;
    funct_t     fn;
    logic       vld_q, halt_q;
    logic [CNT_W-1:0] cnt;
    logic [4:0] ld_dst;
    logic       advance, stall, accept, lw_hz, rs_use, rt_use;

    assign op = opcode_t'(instruction[31:26]);
    assign fn = funct_t'(instruction[5:0]);

    always_comb begin
        d        = '0;
        d.op     = op;
        d.rs     = instruction[25:21];
        d.rt     = instruction[20:16];
        d.wsel   = instruction[20:16];
        d.sa     = instruction[10:6];
        d.imm    = instruction[15:0];
        d.aluop  = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                d.wsel  = instruction[15:11];
                d.regwr = 1'b1;
                case (fn)
                    F_SLL:         begin d.aluop = ALU_SLL; d.alusrc = 2'b10; end
                    F_SRL:         begin d.aluop = ALU_SRL; d.alusrc = 2'b10; end
                    F_JR:          begin d.regwr = 1'b0; d.isjr = 1'b1; end
                    F_ADD, F_ADDU: d.aluop = ALU_ADD;
                    F_SUB, F_SUBU: d.aluop = ALU_SUB;
                    F_AND:         d.aluop = ALU_AND;
                    F_OR:          d.aluop = ALU_OR;
                    F_XOR:         d.aluop = ALU_XOR;
                    F_NOR:         d.aluop = ALU_NOR;
                    F_SLT:         d.aluop = ALU_SLT;
                    F_SLTU:        d.aluop = ALU_SLTU;
                    default:       d.regwr = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin d.extop = 1'b1; d.alusrc = 2'b01; d.regwr = 1'b1; end
            OP_SLTI:  begin d.aluop = ALU_SLT;  d.extop = 1'b1; d.alusrc = 2'b01; d.regwr = 1'b1; end
            OP_SLTIU: begin d.aluop = ALU_SLTU; d.extop = 1'b1; d.alusrc = 2'b01; d.regwr = 1'b1; end
            OP_ANDI:  begin d.aluop = ALU_AND; d.alusrc = 2'b01; d.regwr = 1'b1; end
            OP_ORI:   begin d.aluop = ALU_OR;  d.alusrc = 2'b01; d.regwr = 1'b1; end
            OP_XORI:  begin d.aluop = ALU_XOR; d.alusrc = 2'b01; d.regwr = 1'b1; end
            OP_BEQ, OP_BNE: begin d.aluop = ALU_XOR; d.extop = 1'b1; end
            OP_LUI:   d.regwr = 1'b1;
            OP_LW: begin
                d.dren = 1'b1; d.memtoreg = 1'b1; d.alusrc = 2'b01;
                d.extop = 1'b1; d.regwr = 1'b1;
            end
            OP_SW:    begin d.dwen = 1'b1; d.alusrc = 2'b01; d.extop = 1'b1; end
            OP_JAL:   begin d.regwr = 1'b1; d.wsel = 5'd31; end
            OP_HALT:  d.is_halt = 1'b1;
            default:  ;
        endcase
    end

    // Which source fields of the incoming word actually read a register.
    assign rs_use = !(op inside {OP_J, OP_JAL, OP_LUI, OP_HALT});
    assign rt_use = op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
    assign stall  = (cnt != '0) &&
                    ((rs_use && d.rs == ld_dst) || (rt_use && d.rt == ld_dst));

    assign advance     = !vld_q || dec_ready;
    assign instr_ready = advance && !stall && !halt_q && !flush;
    assign accept      = instr_valid && instr_ready;
    assign lw_hz       = (LU_BUBBLES != 0) && (op == OP_LW) &&
                         (!ZERO_REG_SKIP || d.wsel != 5'd0);

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            vld_q  <= 1'b0;
            halt_q <= 1'b0;
            bnd_q  <= '0;
            cnt    <= '0;
            ld_dst <= '0;
        end else begin
            if (flush)        vld_q <= 1'b0;
            else if (advance) vld_q <= accept;
            if (accept) bnd_q <= d;
            if (accept && d.is_halt) halt_q <= 1'b1;
            // Counter only burns on advance cycles so a stalled execute
            // stage does not let the hazard window expire early.
            if (flush) begin
                cnt <= '0;
            end else if (accept && lw_hz) begin
                cnt    <= CNT_W'(LU_BUBBLES);
                ld_dst <= d.wsel;
            end else if (advance && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign dec_valid = vld_q;
    assign opcode    = bnd_q.op;
    assign rs        = bnd_q.rs;
    assign rt        = bnd_q.rt;
    assign wsel      = bnd_q.wsel;
    assign shamt     = SHAMT_W'(bnd_q.sa);
    assign imm       = bnd_q.imm;
    assign aluop     = bnd_q.aluop;
    assign alusrc    = bnd_q.alusrc;
    assign extop     = bnd_q.extop;
    assign regwr     = bnd_q.regwr;
    assign memtoreg  = bnd_q.memtoreg;
    assign dren      = bnd_q.dren;
    assign dwen      = bnd_q.dwen;
    assign isjr      = bnd_q.isjr;
    assign halt      = halt_q;
endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Testbench for decode_stage_ctrl: table of single-instruction decodes plus
// hand-written hazard, back-pressure, flush, halt and reset sequences.
// Expected bundles are queued on acceptance and popped on consumption.
module tb_decode_stage_ctrl;
    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wsel;
        logic [31:0] shamt;
        logic [15:0] imm;
        logic [3:0]  aluop;
        logic [1:0]  alusrc;
        logic        extop, regwr, memtoreg, dren, dwen, isjr, halt;
    } bund_t;

    typedef struct {
        logic [31:0] ins;
        bund_t       exp;
    } vec_t;

    localparam logic [3:0] A_SLL = 4'h0, A_ADD = 4'h2, A_SUB = 4'h3, A_AND = 4'h4,
                           A_OR  = 4'h5, A_XOR = 4'h6, A_NOR = 4'h7, A_SLT = 4'hA;

    localparam logic [31:0] I_ADDI = 32'h2002FFFF, I_LW  = 32'h8C280004,
                            I_ADD  = 32'h01084820, I_ORI = 32'h34030005,
                            I_HALT = 32'hFC000000;

    logic        clk, n_rst, instr_valid, instr_ready, flush, dec_valid, dec_ready;
    logic [31:0] instruction, shamt;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, wsel;
    logic [15:0] imm;
    logic [3:0]  aluop;
    logic [1:0]  alusrc;
    logic        extop, regwr, memtoreg, dren, dwen, isjr, halt;

    bund_t act;
    assign act = {opcode, rs, rt, wsel, shamt, imm, aluop, alusrc,
                  extop, regwr, memtoreg, dren, dwen, isjr, halt};

    int    checks = 0;
    int    errors = 0;
    bund_t sb[$];
    vec_t  vecs[14];
    bund_t e_addi, e_lw, e_add, e_ori, e_halt;
    int    w;

    decode_stage_ctrl #(.LU_BUBBLES(1), .SHAMT_W(32), .ZERO_REG_SKIP(1'b1)) dut (
        .clk(clk), .n_rst(n_rst), .instr_valid(instr_valid), .instruction(instruction),
        .instr_ready(instr_ready), .flush(flush), .dec_valid(dec_valid),
        .dec_ready(dec_ready), .opcode(opcode), .rs(rs), .rt(rt), .wsel(wsel),
        .shamt(shamt), .imm(imm), .aluop(aluop), .alusrc(alusrc), .extop(extop),
        .regwr(regwr), .memtoreg(memtoreg), .dren(dren), .dwen(dwen), .isjr(isjr),
        .halt(halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ctl = {extop, regwr, memtoreg, dren, dwen, isjr, halt}
    function automatic bund_t mk(input logic [31:0] ins, input logic [4:0] ws,
                                 input logic [3:0] op, input logic [1:0] src,
                                 input logic [6:0] ctl);
        bund_t b;
        b.op = ins[31:26]; b.rs = ins[25:21]; b.rt = ins[20:16]; b.wsel = ws;
        b.shamt = {27'b0, ins[10:6]}; b.imm = ins[15:0]; b.aluop = op; b.alusrc = src;
        {b.extop, b.regwr, b.memtoreg, b.dren, b.dwen, b.isjr, b.halt} = ctl;
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic chk_b(input string name, input bund_t got, input bund_t req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Entered at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] ins, input bund_t e, input int budget,
                        output int waited);
        waited = -1;
        instr_valid = 1'b1;
        instruction = ins;
        for (int n = 0; n < budget; n++) begin
            #1;
            if (instr_ready) begin
                waited = n;
                sb.push_back(e);
                break;
            end
            @(posedge clk); #1;
        end
        if (waited < 0) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no acceptance required accept of %h", ins);
        end else begin
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!n_rst && dec_valid && dec_ready && !flush) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_bundle: got %h required none", act);
            end else begin
                chk_b("bundle", act, sb.pop_front());
            end
        end
    end

    initial begin
        e_addi = mk(I_ADDI, 5'd2,  A_ADD, 2'b01, 7'b1100000);
        e_lw   = mk(I_LW,   5'd8,  A_ADD, 2'b01, 7'b1111000);
        e_add  = mk(I_ADD,  5'd9,  A_ADD, 2'b00, 7'b0100000);
        e_ori  = mk(I_ORI,  5'd3,  A_OR,  2'b01, 7'b0100000);
        e_halt = mk(I_HALT, 5'd0,  A_ADD, 2'b00, 7'b0000001);
        vecs[0]  = '{I_ADDI, e_addi};
        vecs[1]  = '{32'h2843000A, mk(32'h2843000A, 5'd3,  A_SLT, 2'b01, 7'b1100000)};
        vecs[2]  = '{32'h308500FF, mk(32'h308500FF, 5'd5,  A_AND, 2'b01, 7'b0100000)};
        vecs[3]  = '{32'h38C71234, mk(32'h38C71234, 5'd7,  A_XOR, 2'b01, 7'b0100000)};
        vecs[4]  = '{32'h11090003, mk(32'h11090003, 5'd9,  A_XOR, 2'b00, 7'b1000000)};
        vecs[5]  = '{32'h3C0AABCD, mk(32'h3C0AABCD, 5'd10, A_ADD, 2'b00, 7'b0100000)};
        vecs[6]  = '{32'hAD2B0008, mk(32'hAD2B0008, 5'd11, A_ADD, 2'b01, 7'b1000100)};
        vecs[7]  = '{32'h0C000010, mk(32'h0C000010, 5'd31, A_ADD, 2'b00, 7'b0100000)};
        vecs[8]  = '{32'h014B6022, mk(32'h014B6022, 5'd12, A_SUB, 2'b00, 7'b0100000)};
        vecs[9]  = '{32'h00056880, mk(32'h00056880, 5'd13, A_SLL, 2'b10, 7'b0100000)};
        vecs[10] = '{32'h03E00008, mk(32'h03E00008, 5'd0,  A_ADD, 2'b00, 7'b0000010)};
        vecs[11] = '{32'h7C000000, mk(32'h7C000000, 5'd0,  A_ADD, 2'b00, 7'b0000000)};
        vecs[12] = '{32'h0000003F, mk(32'h0000003F, 5'd0,  A_ADD, 2'b00, 7'b0000000)};
        vecs[13] = '{32'h01AE7827, mk(32'h01AE7827, 5'd15, A_NOR, 2'b00, 7'b0100000)};

        n_rst = 1'b1; instr_valid = 1'b0; instruction = '0; flush = 1'b0; dec_ready = 1'b1;
        step(); step();
        #1;
        chk("reset_valid", {31'b0, dec_valid}, 32'd0);
        chk("reset_halt", {31'b0, halt}, 32'd0);
        chk_b("reset_bundle", act, '0);
        chk("reset_ready", {31'b0, instr_ready}, 32'd1);
        step();
        n_rst = 1'b0;

        // ADDI, latency 1
        send(I_ADDI, e_addi, 4, w);
        chk("addi_wait", w, 0);
        #1;
        chk("addi_valid", {31'b0, dec_valid}, 32'd1);
        chk("addi_wsel", {27'b0, wsel}, 32'd2);
        step();

        foreach (vecs[i]) begin
            send(vecs[i].ins, vecs[i].exp, 4, w);
            chk($sformatf("vec%0d_wait", i), w, 0);
        end

        // load-use: one stall cycle, one bubble
        send(I_LW, e_lw, 4, w);
        chk("lu_lw_wait", w, 0);
        instr_valid = 1'b1; instruction = I_ADD;
        #1 chk("lu_stall", {31'b0, instr_ready}, 32'd0);
        step();
        #1;
        chk("lu_bubble", {31'b0, dec_valid}, 32'd0);
        chk("lu_ready", {31'b0, instr_ready}, 32'd1);
        sb.push_back(e_add);
        step();
        instr_valid = 1'b0;
        #1 chk("lu_emit", {31'b0, dec_valid}, 32'd1);
        step();

        // independent ORI after LW consumes the hazard window
        send(I_LW, e_lw, 4, w);
        send(I_ORI, e_ori, 4, w);
        chk("ori_no_bubble", w, 0);
        send(I_ADD, e_add, 4, w);
        chk("add_after_ori", w, 0);
        step();

        // back-pressure for three cycles
        dec_ready = 1'b0;
        send(I_ADDI, e_addi, 4, w);
        chk("bp_accept", w, 0);
        instr_valid = 1'b1; instruction = I_ORI;
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("bp_ready_low", {31'b0, instr_ready}, 32'd0);
            chk("bp_valid", {31'b0, dec_valid}, 32'd1);
            chk_b("bp_stable", act, e_addi);
            step();
        end
        dec_ready = 1'b1;
        #1 chk("bp_release", {31'b0, instr_ready}, 32'd1);
        sb.push_back(e_ori);
        step();
        instr_valid = 1'b0;
        #1 chk("bp_next_valid", {31'b0, dec_valid}, 32'd1);
        step();

        // flush while stalled on a load-use hazard, execute not ready
        send(I_LW, e_lw, 4, w);
        dec_ready = 1'b0;
        instr_valid = 1'b1; instruction = I_ADD;
        #1 chk("fl_stall", {31'b0, instr_ready}, 32'd0);
        step();
        flush = 1'b1;
        void'(sb.pop_back());
        #1 chk("fl_ready_low", {31'b0, instr_ready}, 32'd0);
        step();
        flush = 1'b0; dec_ready = 1'b1;
        #1;
        chk("fl_valid", {31'b0, dec_valid}, 32'd0);
        chk("fl_resume", {31'b0, instr_ready}, 32'd1);
        sb.push_back(e_add);
        step();
        instr_valid = 1'b0;
        #1 chk("fl_add_valid", {31'b0, dec_valid}, 32'd1);
        step();

        // flush together with dec_ready drops the bundle
        send(I_ADDI, e_addi, 4, w);
        flush = 1'b1;
        void'(sb.pop_back());
        #1 chk("drop_ready_low", {31'b0, instr_ready}, 32'd0);
        step();
        flush = 1'b0;
        #1 chk("drop_valid", {31'b0, dec_valid}, 32'd0);
        step();

        // halt is sticky and blocks acceptance
        send(I_HALT, e_halt, 4, w);
        #1;
        chk("halt_set", {31'b0, halt}, 32'd1);
        chk("halt_valid", {31'b0, dec_valid}, 32'd1);
        instr_valid = 1'b1; instruction = I_ADDI;
        for (int n = 0; n < 4; n++) begin
            step();
            #1;
            chk("halt_block", {31'b0, instr_ready}, 32'd0);
            chk("halt_no_out", {31'b0, dec_valid}, 32'd0);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1 chk("halt_sticky", {31'b0, halt}, 32'd1);

        // asynchronous reset mid-halt
        n_rst = 1'b1;
        #1;
        chk("rst_halt_clr", {31'b0, halt}, 32'd0);
        chk("rst_valid_clr", {31'b0, dec_valid}, 32'd0);
        step();
        n_rst = 1'b0;
        send(I_ADDI, e_addi, 4, w);
        chk("rst_resume", w, 0);
        step(); step();
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
